digitron_scan_display: RTL and testbench
========================================

Name: digitron_scan_display

Overview:
- Parametrised time-multiplexed 7-segment driver: N digits of 4-bit hex, per-digit decimal point, digit enable mask, leading-zero blanking and anti-ghosting blank gap.
- Successor to the fixed single-digit decoder. Sits between counter/score logic and the board's segment/common pins.
- Input frame is snapshotted once per scan frame so a digit never tears mid-frame.

Parameters:
- NUM_DIGITS, 4, digits scanned (2..8).
- TICK_DIV, 50000, CLK cycles per digit slot (1 ms at 50 MHz); minimum 2.
- BLANK_CYCLES, 500, cycles at the start of each slot with all commons inactive; must be < TICK_DIV.
- CS_ACTIVE_LOW, 1, 1 = common-select pins active-low.
- SEG_ACTIVE_LOW, 0, 1 = segment pins active-low (inverts all 8 bits).
- BLINK_FRAMES, 250, frames per blink half-period (used only with the macro).

Ports:
- CLK  in  1  system clock.
- RST_n  in  1  asynchronous active-low reset.
- data  in  4*NUM_DIGITS  hex nibbles; digit i = data[4i+3:4i]; digit 0 is rightmost/least significant.
- dp  in  NUM_DIGITS  decimal point per digit.
- digit_en  in  NUM_DIGITS  1 = digit shown; 0 = slot still scanned but segments dark.
- lz_en  in  1  leading-zero suppression enable.
- blink_mask  in  NUM_DIGITS  digits to blink (ignored without macro).
- Digitron_Out  out  8  segments {dp,g,f,e,d,c,b,a}, registered.
- DigitronCS_Out  out  NUM_DIGITS  one-hot common select, registered.
- frame_start  out  1  one-cycle pulse when the slot index wraps to 0.

Behaviour:
- Reset (async, RST_n low): tick counter 0, idx 0, shadow registers 0. Digitron_Out = all segments off (8'h00, or 8'hFF if SEG_ACTIVE_LOW). DigitronCS_Out all inactive. frame_start 0. Blink phase 0.
- Release: first slot begins the cycle after RST_n deasserts. The first frame displays the shadow value 0 until the first wrap.
- Tick counter: counts 0..TICK_DIV-1 and wraps. At TICK_DIV-1, idx advances; idx = NUM_DIGITS-1 wraps to 0.
- Frame boundary (idx wrapping to 0): latch data, dp, digit_en, lz_en and blink_mask into shadow registers. frame_start = 1 on the same edge.
- Slot timing: commons are inactive while tick count < BLANK_CYCLES. Otherwise the common for idx is active. Outputs are registered, so pins lag the internal count by 1 cycle.
- Segment value is driven throughout the slot; only the common is gated by the blank gap.
- Glyphs:
  - 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - A-F: 77 7C 39 5E 79 71.
  - Bit 7 = shadow dp[idx].
- Digit idx is dark (8'h00 before polarity inversion, dp included) when any of these holds:
  - digit_en[idx] = 0.
  - lz_en = 1, idx > 0, and all shadow nibbles from NUM_DIGITS-1 down to idx are zero. Digit 0 is never suppressed by lz.
- A dark digit still asserts its common; only the segments are off.
- Input changes mid-frame are invisible until the next frame boundary. Multiple changes within one frame: only the value at the boundary edge is shown.
- Polarity inversion is applied last, after blanking.

Optional Feature:
- Macro DIGITRON_BLINK_EN.
- Defined:
  - Frame counter counts frame_start pulses; every BLINK_FRAMES frames, blink phase toggles.
  - While phase = 1, digits with shadow blink_mask set are dark.
  - Phase and frame counter reset to 0.
- Undefined:
  - No frame/phase counters are synthesised.
  - blink_mask is sampled but has no effect; output is identical to the macro-off behaviour above.

Decomposition:
- Package digitron_pkg:
  - segment glyph constants for 0-F.
  - SEG_OFF constant.
  - function hex_to_seg(nibble) returning 7 bits.
- Sub-module digitron_seg_decode: combinational nibble+dp+blank to 8-bit segment code. It is the only place glyphs are encoded.
- Top holds the counters, shadow registers and output registers.

Test Plan:
All scenarios use NUM_DIGITS=4, TICK_DIV=4, BLANK_CYCLES=1 unless stated.
- Reset: hold RST_n low for 3 cycles mid-slot → Digitron_Out=00, DigitronCS_Out=4'b1111 within the same cycle (async); after release, first active CS=4'b1110 at cycle 2.
- Scan: data=16'h1234, digit_en=F, lz_en=0 → per 4-cycle slot, CS 1110/1101/1011/0111 paired with 66/4F/5B/06; CS=1111 on the first cycle of each slot; frame_start every 16 cycles.
- Leading zeros: data=16'h0050, lz_en=1 → digits 3,2 dark (00), digit1=6D, digit0=3F; data=0000 with lz_en=1 → only digit0 shows 3F.
- Hex/dp/enable: data=16'hAF0C, dp=4'b0010, digit_en=4'b1011 → digit0=39, digit1=BF, digit2 dark, digit3=77.
- Tearing: change data from 1111 to 2222 mid-frame at idx=2 → digits 2,3 still show 06 until frame_start; next frame all 5B.
- Blink (macro on, BLINK_FRAMES=2): blink_mask=4'b0001, data=0008 → digit0 shows 7F for 2 frames, dark for 2 frames, repeating; with the macro off, always 7F.

Source files
------------

// File: rtl/digitron_pkg.sv
// -----------------------------------------------------------------------------
// digitron_pkg
// Shared constants for the multiplexed 7-segment display driver.
//   - GLYPH_0 .. GLYPH_F : 7-bit segment patterns {g,f,e,d,c,b,a}, active-high
//   - SEG_OFF            : 8-bit all-segments-off code (before polarity)
//   - hex_to_seg()       : nibble -> 7-bit glyph lookup
// -----------------------------------------------------------------------------
package digitron_pkg;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    localparam logic [7:0] SEG_OFF = 8'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = GLYPH_0;
            4'h1:    seg = GLYPH_1;
            4'h2:    seg = GLYPH_2;
            4'h3:    seg = GLYPH_3;
            4'h4:    seg = GLYPH_4;
            4'h5:    seg = GLYPH_5;
            4'h6:    seg = GLYPH_6;
            4'h7:    seg = GLYPH_7;
            4'h8:    seg = GLYPH_8;
            4'h9:    seg = GLYPH_9;
            4'hA:    seg = GLYPH_A;
            4'hB:    seg = GLYPH_B;
            4'hC:    seg = GLYPH_C;
            4'hD:    seg = GLYPH_D;
            4'hE:    seg = GLYPH_E;
            default: seg = GLYPH_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/digitron_seg_decode.sv
// -----------------------------------------------------------------------------
// digitron_seg_decode
// Combinational nibble + decimal point + blank -> 8-bit segment code
// {dp,g,f,e,d,c,b,a}, active-high. Blank forces every segment off, dp included.
// Ports:
//   nibble_i  [3:0]  hex digit value
//   dp_i             decimal point request
//   blank_i          1 = digit dark
//   seg_o     [7:0]  segment code (polarity applied by the caller)
// -----------------------------------------------------------------------------
module digitron_seg_decode
    import digitron_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        if (blank_i) begin
            seg_o = SEG_OFF;
        end else begin
            seg_o = {dp_i, hex_to_seg(nibble_i)};
        end
    end

endmodule

// File: rtl/digitron_scan_display.sv
// -----------------------------------------------------------------------------
// digitron_scan_display
// Time-multiplexed N-digit 7-segment driver with per-digit dp, enable mask,
// leading-zero blanking and an anti-ghosting gap at the start of each slot.
// The input frame is copied into shadow registers when the slot index wraps
// to 0, so a frame is never torn by mid-frame input changes.
//
// Optional feature macro: DIGITRON_BLINK_EN
//   defined   -> frame counter + blink phase; digits in blink_mask go dark
//                while the phase is 1 (phase toggles every BLINK_FRAMES frames)
//   undefined -> no blink logic; blink_mask is latched but has no effect
//
// Ports:
//   CLK, RST_n      clock, asynchronous active-low reset
//   data            hex nibbles, digit i = data[4i+3:4i], digit 0 rightmost
//   dp              decimal point per digit
//   digit_en        1 = digit shown, 0 = slot scanned with segments dark
//   lz_en           leading-zero suppression enable
//   blink_mask      digits to blink (macro only)
//   Digitron_Out    registered segments {dp,g,f,e,d,c,b,a}
//   DigitronCS_Out  registered one-hot common select
//   frame_start     one-cycle pulse when the slot index wraps to 0
// -----------------------------------------------------------------------------
module digitron_scan_display
    import digitron_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int TICK_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int CS_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int BLINK_FRAMES   = 250
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7:0]              Digitron_Out,
    output logic [NUM_DIGITS-1:0]   DigitronCS_Out,
    output logic                    frame_start
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] BLANK_LIM = TW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    localparam logic [7:0]            SEG_RST = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] CS_RST  = (CS_ACTIVE_LOW != 0) ? '1 : '0;

    // Slot counters
    logic [TW-1:0] tick_q, tick_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          slot_end;
    logic          frame_wrap;

    // Shadow copy of the input frame
    logic [4*NUM_DIGITS-1:0] data_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   en_q;
    logic                    lz_q;
    logic [NUM_DIGITS-1:0]   blink_q;

    // Output registers
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] cs_q, cs_d;
    logic                  fs_q, fs_d;

    // Current-digit selection
    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       cur_en;
    logic       cur_blink;
    logic       lz_dark;
    logic       zero_above;
    logic       blink_dark;
    logic       dark;
    logic [7:0] seg_raw;
    logic [NUM_DIGITS-1:0] cs_act;

    assign slot_end   = (tick_q == TICK_LAST);
    assign frame_wrap = slot_end && (idx_q == IDX_LAST);

    always_comb begin
        tick_d = slot_end ? '0 : tick_q + TW'(1);
        idx_d  = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // Walk from the most significant digit down so zero_above holds
    // "every nibble from the top down to this one is zero" at each step.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        cur_blink  = 1'b0;
        lz_dark    = 1'b0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (data_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                cur_nib   = data_q[4*i +: 4];
                cur_dp    = dp_q[i];
                cur_en    = en_q[i];
                cur_blink = blink_q[i];
                // Digit 0 always shows, so a zero value reads "0".
                lz_dark   = lz_q && (i > 0) && zero_above;
            end
        end
    end

`ifdef DIGITRON_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (frame_wrap) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blink_dark = phase_q & cur_blink;
`else
    logic unused_blink_sel;
    assign unused_blink_sel = cur_blink;
    assign blink_dark       = 1'b0;
`endif

    assign dark = !cur_en || lz_dark || blink_dark;

    digitron_seg_decode u_seg_decode (
        .nibble_i (cur_nib),
        .dp_i     (cur_dp),
        .blank_i  (dark),
        .seg_o    (seg_raw)
    );

    // Segments are driven for the whole slot; only the common honours the gap.
    always_comb begin
        cs_act = '0;
        if (tick_q >= BLANK_LIM) begin
            cs_act = NUM_DIGITS'(1) << idx_q;
        end
        cs_d  = (CS_ACTIVE_LOW != 0) ? ~cs_act : cs_act;
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        fs_d  = frame_wrap;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            tick_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            dp_q    <= '0;
            en_q    <= '0;
            lz_q    <= 1'b0;
            blink_q <= '0;
            seg_q   <= SEG_RST;
            cs_q    <= CS_RST;
            fs_q    <= 1'b0;
        end else begin
            tick_q <= tick_d;
            idx_q  <= idx_d;
            if (frame_wrap) begin
                data_q  <= data;
                dp_q    <= dp;
                en_q    <= digit_en;
                lz_q    <= lz_en;
                blink_q <= blink_mask;
            end
            seg_q <= seg_d;
            cs_q  <= cs_d;
            fs_q  <= fs_d;
        end
    end

    assign Digitron_Out   = seg_q;
    assign DigitronCS_Out = cs_q;
    assign frame_start    = fs_q;

endmodule

// File: tb/tb_digitron_scan_display.sv
// -----------------------------------------------------------------------------
// tb_digitron_scan_display
// Bench for digitron_scan_display with NUM_DIGITS=4, TICK_DIV=4,
// BLANK_CYCLES=1, active-low commons, active-high segments, BLINK_FRAMES=2.
// A frame-level model (edge count since reset -> slot/tick/frame, plus a table
// of input snapshots per frame) predicts the pins every cycle; directed
// sections pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_digitron_scan_display;

    localparam int N     = 4;
    localparam int TD    = 4;
    localparam int BC    = 1;
    localparam int BF    = 2;
    localparam int SLOTS = TD * N;
    localparam int MAXF  = 256;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        lz_en;
    logic [3:0]  blink_mask;
    logic [7:0]  Digitron_Out;
    logic [3:0]  DigitronCS_Out;
    logic        frame_start;

    digitron_scan_display #(
        .NUM_DIGITS     (N),
        .TICK_DIV       (TD),
        .BLANK_CYCLES   (BC),
        .CS_ACTIVE_LOW  (1),
        .SEG_ACTIVE_LOW (0),
        .BLINK_FRAMES   (BF)
    ) dut (
        .CLK            (CLK),
        .RST_n          (RST_n),
        .data           (data),
        .dp             (dp),
        .digit_en       (digit_en),
        .lz_en          (lz_en),
        .blink_mask     (blink_mask),
        .Digitron_Out   (Digitron_Out),
        .DigitronCS_Out (DigitronCS_Out),
        .frame_start    (frame_start)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [15:0] f_data [MAXF];
    logic [3:0]  f_dp   [MAXF];
    logic [3:0]  f_en   [MAXF];
    logic [3:0]  f_bm   [MAXF];
    logic        f_lz   [MAXF];

    // Edges seen since reset release.
    int k;
    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) k <= 0;
        else        k <= k + 1;
    end

    // Pins after edge kk show the state reached after edge kk-1.
    function automatic void model_pins(input int kk, output logic [7:0] seg,
                                       output logic [3:0] cs, output logic fs);
        int m, tick, idx, f;
        logic [15:0] d;
        logic [3:0]  one;
        logic        dark;
        m    = kk - 1;
        tick = m % TD;
        idx  = (m / TD) % N;
        f    = m / SLOTS;
        one  = 4'b0001;
        cs   = (tick >= BC) ? ~(one << idx) : 4'hF;
        d    = f_data[f];
        dark = !f_en[f][idx] || (f_lz[f] && idx > 0 && (d >> (4 * idx)) == 16'h0);
`ifdef DIGITRON_BLINK_EN
        if (((f / BF) % 2) == 1 && f_bm[f][idx]) dark = 1'b1;
`endif
        seg = dark ? 8'h00 : {f_dp[f][idx], glyph[(d >> (4 * idx)) & 16'hF]};
        fs  = (kk % SLOTS == 0);
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        logic [7:0] e_seg;
        logic [3:0] e_cs;
        logic       e_fs;
        if (!RST_n) begin
            f_data[0] = '0; f_dp[0] = '0; f_en[0] = '0; f_bm[0] = '0; f_lz[0] = 1'b0;
            check("rst_cs", {4'h0, DigitronCS_Out}, 8'h0F);
            check("rst_seg", Digitron_Out, 8'h00);
            check("rst_fs", {7'h0, frame_start}, 8'h00);
        end else begin
            // Inputs present now are what the next wrap edge latches.
            if (k % SLOTS == SLOTS - 1 && (k + 1) / SLOTS < MAXF) begin
                f_data[(k + 1) / SLOTS] = data;
                f_dp[(k + 1) / SLOTS]   = dp;
                f_en[(k + 1) / SLOTS]   = digit_en;
                f_bm[(k + 1) / SLOTS]   = blink_mask;
                f_lz[(k + 1) / SLOTS]   = lz_en;
            end
            if (k == 0) begin
                check("idle_cs", {4'h0, DigitronCS_Out}, 8'h0F);
                check("idle_seg", Digitron_Out, 8'h00);
            end else if ((k - 1) / SLOTS < MAXF) begin
                model_pins(k, e_seg, e_cs, e_fs);
                check("mdl_cs", {4'h0, DigitronCS_Out}, {4'h0, e_cs});
                check("mdl_seg", Digitron_Out, e_seg);
                check("mdl_fs", {7'h0, frame_start}, {7'h0, e_fs});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [15:0] d, input logic [3:0] p, input logic [3:0] en,
                         input logic lz, input logic [3:0] bm);
        @(posedge CLK);
        #1;
        data = d; dp = p; digit_en = en; lz_en = lz; blink_mask = bm;
    endtask

    task automatic wait_frames(input int n);
        repeat (n * SLOTS) @(posedge CLK);
        #1;
    endtask

    // Waits (bounded) until the given common is active, then checks segments.
    task automatic expect_digit(input string name, input logic [3:0] cs_want,
                                input logic [7:0] seg_want);
        bit found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge CLK);
            if (DigitronCS_Out === cs_want) found = 1;
        end
        if (!found) check({name, "_cs_timeout"}, {4'h0, DigitronCS_Out}, {4'h0, cs_want});
        else        check(name, Digitron_Out, seg_want);
    endtask

    task automatic check_frame_period();
        bit found = 0;
        int cnt = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge CLK);
            if (frame_start === 1'b1) found = 1;
        end
        if (!found) begin
            check("fs_timeout", {7'h0, frame_start}, 8'h01);
        end else begin
            found = 0;
            for (int i = 0; i < 64 && !found; i++) begin
                @(negedge CLK);
                cnt++;
                if (frame_start === 1'b1) found = 1;
            end
            check("fs_period", 8'(cnt), 8'(SLOTS));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        data = '0; dp = '0; digit_en = '0; lz_en = 1'b0; blink_mask = '0;
        RST_n = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK) RST_n = 1'b1;
        repeat (5) @(posedge CLK);

        // Asynchronous reset mid-slot
        #2 RST_n = 1'b0;
        #1;
        check("async_rst_cs", {4'h0, DigitronCS_Out}, 8'h0F);
        check("async_rst_seg", Digitron_Out, 8'h00);
        repeat (3) @(posedge CLK);
        @(negedge CLK) RST_n = 1'b1;
        @(negedge CLK);
        check("rel_cycle1_cs", {4'h0, DigitronCS_Out}, 8'h0F);
        @(negedge CLK);
        check("rel_cycle2_cs", {4'h0, DigitronCS_Out}, 8'h0E);

        // Plain scan
        drive(16'h1234, 4'h0, 4'hF, 1'b0, 4'h0);
        wait_frames(2);
        expect_digit("scan_d0", 4'b1110, 8'h66);
        expect_digit("scan_d1", 4'b1101, 8'h4F);
        expect_digit("scan_d2", 4'b1011, 8'h5B);
        expect_digit("scan_d3", 4'b0111, 8'h06);
        check_frame_period();

        // Leading-zero suppression
        drive(16'h0050, 4'h0, 4'hF, 1'b1, 4'h0);
        wait_frames(2);
        expect_digit("lz_d3", 4'b0111, 8'h00);
        expect_digit("lz_d2", 4'b1011, 8'h00);
        expect_digit("lz_d1", 4'b1101, 8'h6D);
        expect_digit("lz_d0", 4'b1110, 8'h3F);
        drive(16'h0000, 4'h0, 4'hF, 1'b1, 4'h0);
        wait_frames(2);
        expect_digit("lz0_d1", 4'b1101, 8'h00);
        expect_digit("lz0_d3", 4'b0111, 8'h00);
        expect_digit("lz0_d0", 4'b1110, 8'h3F);

        // Hex glyphs, decimal point, digit enable
        drive(16'hAF0C, 4'b0010, 4'b1011, 1'b0, 4'h0);
        wait_frames(2);
        expect_digit("hex_d0", 4'b1110, 8'h39);
        expect_digit("hex_d1", 4'b1101, 8'hBF);
        expect_digit("hex_d2", 4'b1011, 8'h00);
        expect_digit("hex_d3", 4'b0111, 8'h77);

        // Mid-frame change must not tear the frame
        drive(16'h1111, 4'h0, 4'hF, 1'b0, 4'h0);
        wait_frames(2);
        expect_digit("tear_pre_d2", 4'b1011, 8'h06);
        drive(16'h2222, 4'h0, 4'hF, 1'b0, 4'h0);
        expect_digit("tear_old_d3", 4'b0111, 8'h06);
        expect_digit("tear_new_d0", 4'b1110, 8'h5B);
        expect_digit("tear_new_d3", 4'b0111, 8'h5B);

        // Blink mask
        drive(16'h0008, 4'h0, 4'hF, 1'b0, 4'b0001);
`ifndef DIGITRON_BLINK_EN
        wait_frames(2);
        expect_digit("noblink_d0", 4'b1110, 8'h7F);
`endif
        wait_frames(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
